// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register for the 5-stage MIPS core.
// It latches the Control EX/M/WB bundles and the decoded operands on each edge.
// It also detects load-use hazards, inserts bubbles, and handles branch flush and external stall.
// A saturating counter records how many hazard bubbles have been inserted.
module id_ex_stage_reg #(
    parameter int DW    = 32,
    parameter int RW    = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       ex_in,
    input  logic [2:0]       m_in,
    input  logic [1:0]       wb_in,
    input  logic [DW-1:0]    pc4_in,
    input  logic [DW-1:0]    rd1_in,
    input  logic [DW-1:0]    rd2_in,
    input  logic [DW-1:0]    imm_in,
    input  logic [RW-1:0]    rs_in,
    input  logic [RW-1:0]    rt_in,
    input  logic [RW-1:0]    rd_in,
    input  logic             flush,
    input  logic             ext_stall,
    output logic [2:0]       ex_out,
    output logic [2:0]       m_out,
    output logic [1:0]       wb_out,
    output logic [DW-1:0]    pc4_out,
    output logic [DW-1:0]    rd1_out,
    output logic [DW-1:0]    rd2_out,
    output logic [DW-1:0]    imm_out,
    output logic [RW-1:0]    rs_out,
    output logic [RW-1:0]    rt_out,
    output logic [RW-1:0]    rd_out,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             lu_hazard,
    output logic [CNT_W-1:0] bubble_cnt
);

    // Increment that sticks at all-ones so the debug count never wraps.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    logic [2:0]       ex_r;
    logic [2:0]       m_r;
    logic [1:0]       wb_r;
    logic [DW-1:0]    pc4_r;
    logic [DW-1:0]    rd1_r;
    logic [DW-1:0]    rd2_r;
    logic [DW-1:0]    imm_r;
    logic [RW-1:0]    rs_r;
    logic [RW-1:0]    rt_r;
    logic [RW-1:0]    rd_r;
    logic [CNT_W-1:0] bubble_cnt_r;
    logic             lu_hazard_s;
    logic             advance_s;

    // Detect a load in EX whose destination (rt) feeds either source of the ID instruction.
    // Register 0 is excluded. Both rs and rt are always compared, so the check is conservative.
    always_comb begin
        lu_hazard_s = 1'b0;
        if (m_r[1] && (rt_r != {RW{1'b0}}) &&
            ((rt_r == rs_in) || (rt_r == rt_in))) begin
            lu_hazard_s = 1'b1;
        end else begin
            lu_hazard_s = 1'b0;
        end
    end

    // Front-end enable: a flush always lets the PC and IF/ID advance; otherwise a hazard or stall freezes them.
    always_comb begin
        advance_s = 1'b1;
        if (flush) begin
            advance_s = 1'b1;
        end else if (lu_hazard_s || ext_stall) begin
            advance_s = 1'b0;
        end else begin
            advance_s = 1'b1;
        end
    end

    // Pipeline register update: reset, then flush, then stall hold, then hazard bubble, then normal load.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_r         <= 3'b000;
            m_r          <= 3'b000;
            wb_r         <= 2'b00;
            pc4_r        <= {DW{1'b0}};
            rd1_r        <= {DW{1'b0}};
            rd2_r        <= {DW{1'b0}};
            imm_r        <= {DW{1'b0}};
            rs_r         <= {RW{1'b0}};
            rt_r         <= {RW{1'b0}};
            rd_r         <= {RW{1'b0}};
            bubble_cnt_r <= {CNT_W{1'b0}};
        end else if (flush) begin
            // The squashed slot becomes a NOP. Its datapath fields are don't-care and are simply loaded.
            ex_r  <= 3'b000;
            m_r   <= 3'b000;
            wb_r  <= 2'b00;
            pc4_r <= pc4_in;
            rd1_r <= rd1_in;
            rd2_r <= rd2_in;
            imm_r <= imm_in;
            rs_r  <= rs_in;
            rt_r  <= rt_in;
            rd_r  <= rd_in;
        end else if (ext_stall) begin
            ex_r <= ex_r;
        end else if (lu_hazard_s) begin
            // The bubble clears MemRead in EX, so the hazard releases on the very next cycle.
            ex_r         <= 3'b000;
            m_r          <= 3'b000;
            wb_r         <= 2'b00;
            pc4_r        <= pc4_in;
            rd1_r        <= rd1_in;
            rd2_r        <= rd2_in;
            imm_r        <= imm_in;
            rs_r         <= rs_in;
            rt_r         <= rt_in;
            rd_r         <= rd_in;
            bubble_cnt_r <= sat_inc(bubble_cnt_r);
        end else begin
            ex_r  <= ex_in;
            m_r   <= m_in;
            wb_r  <= wb_in;
            pc4_r <= pc4_in;
            rd1_r <= rd1_in;
            rd2_r <= rd2_in;
            imm_r <= imm_in;
            rs_r  <= rs_in;
            rt_r  <= rt_in;
            rd_r  <= rd_in;
        end
    end

    assign ex_out      = ex_r;
    assign m_out       = m_r;
    assign wb_out      = wb_r;
    assign pc4_out     = pc4_r;
    assign rd1_out     = rd1_r;
    assign rd2_out     = rd2_r;
    assign imm_out     = imm_r;
    assign rs_out      = rs_r;
    assign rt_out      = rt_r;
    assign rd_out      = rd_r;
    assign bubble_cnt  = bubble_cnt_r;
    assign lu_hazard   = lu_hazard_s;
    assign pc_write    = advance_s;
    assign if_id_write = advance_s;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg.
// It runs directed scenarios followed by a randomized run, checked against a behavioural model.
module tb_id_ex_stage_reg;
    localparam int DW    = 32;
    localparam int RW    = 5;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [2:0]       ex_in, m_in;
    logic [1:0]       wb_in;
    logic [DW-1:0]    pc4_in, rd1_in, rd2_in, imm_in;
    logic [RW-1:0]    rs_in, rt_in, rd_in;
    logic             flush, ext_stall;
    logic [2:0]       ex_out, m_out;
    logic [1:0]       wb_out;
    logic [DW-1:0]    pc4_out, rd1_out, rd2_out, imm_out;
    logic [RW-1:0]    rs_out, rt_out, rd_out;
    logic             pc_write, if_id_write, lu_hazard;
    logic [CNT_W-1:0] bubble_cnt;

    id_ex_stage_reg #(.DW(DW), .RW(RW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .ex_in(ex_in), .m_in(m_in), .wb_in(wb_in),
        .pc4_in(pc4_in), .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
        .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .flush(flush), .ext_stall(ext_stall),
        .ex_out(ex_out), .m_out(m_out), .wb_out(wb_out), .pc4_out(pc4_out),
        .rd1_out(rd1_out), .rd2_out(rd2_out), .imm_out(imm_out), .rs_out(rs_out),
        .rt_out(rt_out), .rd_out(rd_out), .pc_write(pc_write), .if_id_write(if_id_write),
        .lu_hazard(lu_hazard), .bubble_cnt(bubble_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model of the register contents.
    typedef struct {
        logic [2:0]    ex, m;
        logic [1:0]    wb;
        logic [DW-1:0] pc4, rd1, rd2, imm;
        logic [RW-1:0] rs, rt, rd;
        int            cnt;
        bit            dp_valid;  // datapath fields are don't-care right after a flush
    } mdl_t;
    mdl_t mdl;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A load sits in EX, writes a non-zero rt, and that register is read by the ID instruction.
    function automatic bit model_hazard();
        return (mdl.m[1] == 1'b1) && (mdl.rt != 0) && (mdl.rt == rs_in || mdl.rt == rt_in);
    endfunction

    task automatic load_inputs(input bit keep_ctrl);
        mdl.ex  = keep_ctrl ? ex_in : 3'b000;
        mdl.m   = keep_ctrl ? m_in  : 3'b000;
        mdl.wb  = keep_ctrl ? wb_in : 2'b00;
        mdl.pc4 = pc4_in; mdl.rd1 = rd1_in; mdl.rd2 = rd2_in; mdl.imm = imm_in;
        mdl.rs  = rs_in;  mdl.rt  = rt_in;  mdl.rd  = rd_in;
    endtask

    // One clock: check the combinational outputs before the edge, advance the model, then check the registers.
    task automatic step(input string tag);
        bit hz, pw;
        #1;
        hz = model_hazard();
        pw = flush || !(hz || ext_stall);
        chk({tag, ".lu_hazard"}, 64'(lu_hazard), 64'(hz));
        chk({tag, ".pc_write"}, 64'(pc_write), 64'(pw));
        chk({tag, ".if_id_write"}, 64'(if_id_write), 64'(pw));
        @(posedge clk);
        if (rst) begin
            mdl = '{3'b000, 3'b000, 2'b00, '0, '0, '0, '0, '0, '0, '0, 0, 1'b1};
        end else if (flush) begin
            load_inputs(1'b0);
            mdl.dp_valid = 1'b0;
        end else if (ext_stall) begin
            mdl.cnt = mdl.cnt;
        end else if (hz) begin
            load_inputs(1'b0);
            mdl.dp_valid = 1'b1;
            if (mdl.cnt < CMAX) mdl.cnt = mdl.cnt + 1;
        end else begin
            load_inputs(1'b1);
            mdl.dp_valid = 1'b1;
        end
        #1;
        chk({tag, ".ex_out"}, 64'(ex_out), 64'(mdl.ex));
        chk({tag, ".m_out"}, 64'(m_out), 64'(mdl.m));
        chk({tag, ".wb_out"}, 64'(wb_out), 64'(mdl.wb));
        chk({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'(mdl.cnt));
        if (mdl.dp_valid) begin
            chk({tag, ".pc4_out"}, 64'(pc4_out), 64'(mdl.pc4));
            chk({tag, ".rd1_out"}, 64'(rd1_out), 64'(mdl.rd1));
            chk({tag, ".rd2_out"}, 64'(rd2_out), 64'(mdl.rd2));
            chk({tag, ".imm_out"}, 64'(imm_out), 64'(mdl.imm));
            chk({tag, ".rs_out"}, 64'(rs_out), 64'(mdl.rs));
            chk({tag, ".rt_out"}, 64'(rt_out), 64'(mdl.rt));
            chk({tag, ".rd_out"}, 64'(rd_out), 64'(mdl.rd));
        end
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [2:0] ex, input logic [2:0] m, input logic [1:0] wb,
                             input logic [RW-1:0] rs, input logic [RW-1:0] rt, input logic [DW-1:0] d1);
        ex_in = ex; m_in = m; wb_in = wb; rs_in = rs; rt_in = rt; rd1_in = d1;
        rd_in = 5'd3; pc4_in = 32'h100 + d1; rd2_in = ~d1; imm_in = d1 ^ 32'h00FF_0000;
    endtask

    initial begin
        mdl = '{3'b000, 3'b000, 2'b00, '0, '0, '0, '0, '0, '0, '0, 0, 1'b1};
        rst = 1'b1; flush = 1'b0; ext_stall = 1'b0;
        set_instr(3'b000, 3'b000, 2'b00, 5'd0, 5'd0, 32'h0);
        @(negedge clk);
        // 1: reset for two cycles
        step("rst0");
        step("rst1");
        chk("rst.bubble_cnt_zero", 64'(bubble_cnt), 64'd0);
        chk("rst.pc_write_one", 64'(pc_write), 64'd1);
        rst = 1'b0;

        // 2: R-type instruction
        set_instr(3'b110, 3'b000, 2'b10, 5'd1, 5'd2, 32'h5);
        step("rtype");
        chk("rtype.ex_const", 64'(ex_out), 64'h6);
        chk("rtype.wb_const", 64'(wb_out), 64'h2);
        chk("rtype.rd1_const", 64'(rd1_out), 64'h5);

        // 3: lw followed by a dependent instruction
        set_instr(3'b011, 3'b010, 2'b11, 5'd1, 5'd8, 32'h11);
        step("lw8");
        set_instr(3'b110, 3'b000, 2'b10, 5'd8, 5'd2, 32'h22);
        #1;
        chk("lu.hazard_const", 64'(lu_hazard), 64'd1);
        chk("lu.pc_write_const", 64'(pc_write), 64'd0);
        step("lu_bubble");
        chk("lu.m_zero", 64'(m_out), 64'd0);
        chk("lu.cnt_one", 64'(bubble_cnt), 64'd1);
        step("lu_release");
        chk("lu.ex_latched", 64'(ex_out), 64'h6);

        // 4: lw to register 0 never stalls
        set_instr(3'b011, 3'b010, 2'b11, 5'd1, 5'd0, 32'h33);
        step("lw0");
        set_instr(3'b110, 3'b000, 2'b10, 5'd0, 5'd0, 32'h44);
        step("lw0_use");
        chk("lw0.cnt_one", 64'(bubble_cnt), 64'd1);

        // 5: flush wins over a simultaneous load-use hazard
        set_instr(3'b011, 3'b010, 2'b11, 5'd1, 5'd9, 32'h55);
        step("lw9");
        set_instr(3'b110, 3'b000, 2'b10, 5'd9, 5'd2, 32'h66);
        flush = 1'b1;
        step("flush_lu");
        chk("flush.cnt_one", 64'(bubble_cnt), 64'd1);
        flush = 1'b0;

        // 6: external stall freezes everything for three cycles
        set_instr(3'b110, 3'b000, 2'b10, 5'd4, 5'd5, 32'h77);
        step("pre_stall");
        set_instr(3'b001, 3'b001, 2'b01, 5'd6, 5'd7, 32'h88);
        ext_stall = 1'b1;
        step("stall0");
        step("stall1");
        step("stall2");
        chk("stall.rd1_held", 64'(rd1_out), 64'h77);
        ext_stall = 1'b0;
        step("stall_release");
        chk("stall.rd1_loaded", 64'(rd1_out), 64'h88);

        // Stall during a hazard: hold, no count, the hazard persists until the stall drops
        set_instr(3'b011, 3'b010, 2'b11, 5'd1, 5'd12, 32'h99);
        step("lw12");
        set_instr(3'b110, 3'b000, 2'b10, 5'd2, 5'd12, 32'hAA);
        ext_stall = 1'b1;
        step("stall_lu0");
        step("stall_lu1");
        ext_stall = 1'b0;
        step("stall_lu_bubble");
        step("stall_lu_release");

        // Reset in the middle of a hazard
        set_instr(3'b011, 3'b010, 2'b11, 5'd1, 5'd13, 32'hBB);
        step("lw13");
        set_instr(3'b110, 3'b000, 2'b10, 5'd13, 5'd2, 32'hCC);
        rst = 1'b1;
        step("rst_mid_hazard");
        chk("rstmid.pc_write", 64'(pc_write), 64'd1);
        rst = 1'b0;

        // Counter saturation
        for (int i = 0; i < CMAX + 4; i++) begin
            set_instr(3'b011, 3'b010, 2'b11, 5'd1, 5'd3, 32'(i));
            step("sat_lw");
            set_instr(3'b110, 3'b000, 2'b10, 5'd3, 5'd1, 32'(i + 100));
            step("sat_use");
        end
        chk("sat.cnt_max", 64'(bubble_cnt), 64'(CMAX));

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            ex_in = 3'($urandom); m_in = 3'($urandom); wb_in = 2'($urandom);
            pc4_in = $urandom; rd1_in = $urandom; rd2_in = $urandom; imm_in = $urandom;
            rs_in = 5'($urandom_range(0, 3)); rt_in = 5'($urandom_range(0, 3));
            rd_in = 5'($urandom);
            flush = ($urandom_range(0, 9) == 0);
            ext_stall = ($urandom_range(0, 6) == 0);
            rst = ($urandom_range(0, 299) == 0);
            step("rand");
        end
        rst = 1'b0; flush = 1'b0; ext_stall = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
